// File: rtl/clkgen_pkg.sv
// Shared definitions for the CPU clock generator: sequencer state encoding
// and the default divisor loaded at reset.
package clkgen_pkg;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HALT = 2'd1,
      ST_STEP = 2'd2
   } clk_state_e;

   // Default reset divisor: 2**(w-1)-1, the slowest "half range" setting.
   function automatic int unsigned div_reset_default(input int unsigned w);
      return (32'd1 << (w - 32'd1)) - 32'd1;
   endfunction

endpackage

// File: rtl/cpu_reset_seq.sv
// Holds the CPU in reset until RESET_CYCLES CPU falling edges have been seen.
// cpu_fall is the fall strobe for the current edge (not the registered
// pulse), so cpu_reset drops in the same cycle the Nth cpu_fall appears.
// RESET_CYCLES is expected to be at least 1.
module cpu_reset_seq #(
   parameter int unsigned RESET_CYCLES = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic cpu_fall,
   output logic cpu_reset
);

   localparam int unsigned CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(RESET_CYCLES - 1);

   logic [CW-1:0] fall_cnt;

   // Count falls while reset is held; release on the last one and stay released.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fall_cnt  <= '0;
         cpu_reset <= 1'b1;
      end else if (cpu_reset && cpu_fall) begin
         if (fall_cnt == LAST) cpu_reset <= 1'b0;
         else                  fall_cnt  <= fall_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/cpu_clk_gen.sv
// CPU clock generator: divides clk by 2*(div_active+1) into a registered
// 50%-duty cpu_clk with rise/fall enable pulses, supports halt and
// single-step, deferred divisor changes, and a post-reset CPU reset window.
module cpu_clk_gen
   import clkgen_pkg::*;
#(
   parameter int unsigned DIV_W        = 25,
   parameter int unsigned DIV_RESET    = div_reset_default(DIV_W),
   parameter int unsigned RESET_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [DIV_W-1:0] div,
   input  logic             div_load,
   input  logic             run,
   input  logic             step,
   output logic             cpu_clk,
   output logic             cpu_rise,
   output logic             cpu_fall,
   output logic             cpu_reset,
   output logic             halted,
   output logic [DIV_W-1:0] div_active
);

   localparam logic [DIV_W-1:0] DIV_RST_V = DIV_RESET[DIV_W-1:0];

   clk_state_e       state, st_nxt;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] pend_div;
   logic             pend_vld;
   logic             tc, halt_now, rise_evt, fall_evt, apply;

   // Terminal count of the half-period; the counter only runs outside HALT.
   assign tc       = (state != ST_HALT) && (cnt == div_active);
   // A rising toggle that is due in RUN with run low parks the clock low instead.
   assign halt_now = (state == ST_RUN) && tc && !cpu_clk && !run;
   assign rise_evt = tc && !cpu_clk && !halt_now;
   assign fall_evt = tc && cpu_clk;
   // Divisor changes land only at a period boundary (fall) or while parked.
   assign apply    = pend_vld && (fall_evt || (state == ST_HALT));

   // Next-state: HALT waits for run/step, STEP ends on its one fall.
   always_comb begin
      st_nxt = state;
      case (state)
         ST_RUN:  if (halt_now) st_nxt = ST_HALT;
         ST_HALT: if (run)       st_nxt = ST_RUN;
                  else if (step) st_nxt = ST_STEP;
         ST_STEP: if (fall_evt)  st_nxt = run ? ST_RUN : ST_HALT;
         default: st_nxt = ST_RUN;
      endcase
   end

   // Clock register, pulses, half-period counter, state and divisor registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= ST_RUN;
         halted     <= 1'b0;
         cnt        <= '0;
         cpu_clk    <= 1'b0;
         cpu_rise   <= 1'b0;
         cpu_fall   <= 1'b0;
         div_active <= DIV_RST_V;
         pend_div   <= '0;
         pend_vld   <= 1'b0;
      end else begin
         state    <= st_nxt;
         halted   <= (st_nxt == ST_HALT);
         cpu_rise <= rise_evt;
         cpu_fall <= fall_evt;
         if (rise_evt || fall_evt) cpu_clk <= ~cpu_clk;

         if ((state == ST_HALT) || tc) cnt <= '0;
         else                          cnt <= cnt + 1'b1;

         // A load on the apply cycle wins the pending slot with the new value.
         if (apply) div_active <= pend_div;
         if (div_load) begin
            pend_div <= div;
            pend_vld <= 1'b1;
         end else if (apply) begin
            pend_vld <= 1'b0;
         end
      end
   end

   cpu_reset_seq #(
      .RESET_CYCLES(RESET_CYCLES)
   ) u_reset_seq (
      .clk      (clk),
      .reset_n  (reset_n),
      .cpu_fall (fall_evt),
      .cpu_reset(cpu_reset)
   );

endmodule

// File: tb/tb_cpu_clk_gen.sv
// Bench for cpu_clk_gen (DIV_W=4, DIV_RESET=1, RESET_CYCLES=2): directed
// table, hand-written halt/step/div0/reset sequences, then random stimulus,
// with a cycle-level reference model compared on every clock.
module tb_cpu_clk_gen;

   localparam int DW = 4;
   localparam int RC = 2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0, div_load = 1'b0, run = 1'b0, step = 1'b0;
   logic [DW-1:0] div = '0;
   logic          cpu_clk, cpu_rise, cpu_fall, cpu_reset, halted;
   logic [DW-1:0] div_active;

   int total = 0;
   int bad   = 0;

   cpu_clk_gen #(.DIV_W(DW), .DIV_RESET(1), .RESET_CYCLES(RC)) dut (
      .clk(clk), .reset_n(reset_n), .div(div), .div_load(div_load),
      .run(run), .step(step), .cpu_clk(cpu_clk), .cpu_rise(cpu_rise),
      .cpu_fall(cpu_fall), .cpu_reset(cpu_reset), .halted(halted),
      .div_active(div_active)
   );

   always #5 clk = ~clk;

   // Reference model: mode 0=run 1=halt 2=step; m_left = clk cycles still
   // to go in the current half period, m_falls = CPU falls since reset.
   int m_mode, m_left, m_act, m_pend_v, m_falls;
   bit m_pend, m_lvl, m_rise, m_fall, m_halt;
   bit chk_en = 1'b0;

   task automatic model_edge();
      bit due;
      int nm;
      if (!reset_n) begin
         m_lvl = 0; m_rise = 0; m_fall = 0; m_mode = 0; m_act = 1;
         m_pend = 0; m_pend_v = 0; m_falls = 0; m_left = 2; m_halt = 0;
         chk_en = 1'b1;
         return;
      end
      if (!chk_en) return;
      m_rise = 0; m_fall = 0; nm = m_mode;
      due = (m_mode != 1) && (m_left == 1);
      if (m_mode == 1) begin
         if (run) nm = 0; else if (step) nm = 2;
      end else if (due) begin
         if (!m_lvl && m_mode == 0 && !run) nm = 1;
         else begin
            m_lvl = !m_lvl; m_rise = m_lvl; m_fall = !m_lvl;
            if (m_fall) begin
               m_falls++;
               if (m_mode == 2) nm = run ? 0 : 1;
            end
         end
      end else m_left--;
      if (m_pend && (m_fall || m_mode == 1)) begin m_act = m_pend_v; m_pend = 0; end
      if (div_load) begin m_pend_v = int'(div); m_pend = 1; end
      if (m_mode == 1 || due) m_left = m_act + 1;
      m_mode = nm;
      m_halt = (nm == 1);
   endtask

   function automatic logic [8:0] dut_vec();
      return {cpu_clk, cpu_rise, cpu_fall, cpu_reset, halted, div_active};
   endfunction

   function automatic logic [8:0] model_vec();
      return {m_lvl, m_rise, m_fall, (m_falls < RC), m_halt, 4'(m_act)};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, got, exp);
      end
   endtask

   // One clock: model advances on the edge, DUT compared on the falling edge.
   task automatic cyc();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (chk_en) check("model", 32'(dut_vec()), 32'(model_vec()));
   endtask

   typedef struct packed {
      logic          rn;
      logic [DW-1:0] d;
      logic          ld, r, s;
      logic [8:0]    exp;   // {clk, rise, fall, cpu_reset, halted, div_active}
   } vec_t;

   function automatic vec_t mk(input logic rn, input logic [DW-1:0] d,
                               input logic ld, input logic r, input logic s,
                               input logic [8:0] e);
      vec_t v;
      v.rn = rn; v.d = d; v.ld = ld; v.r = r; v.s = s; v.exp = e;
      return v;
   endfunction

   vec_t tbl[21];

   initial begin
      int n, nr, nf, ra, fa, viol;
      bit hf, prev;

      // Reset, free run at period 4, then a div=3 load mid high phase.
      tbl[0]  = mk(0, 0, 0, 1, 0, 9'b0_0_0_1_0_0001);
      tbl[1]  = mk(1, 0, 0, 1, 0, 9'b0_0_0_1_0_0001);
      tbl[2]  = mk(1, 0, 0, 1, 0, 9'b1_1_0_1_0_0001);
      tbl[3]  = mk(1, 0, 0, 1, 0, 9'b1_0_0_1_0_0001);
      tbl[4]  = mk(1, 0, 0, 1, 0, 9'b0_0_1_1_0_0001);
      tbl[5]  = mk(1, 0, 0, 1, 0, 9'b0_0_0_1_0_0001);
      tbl[6]  = mk(1, 0, 0, 1, 0, 9'b1_1_0_1_0_0001);
      tbl[7]  = mk(1, 0, 0, 1, 0, 9'b1_0_0_1_0_0001);
      tbl[8]  = mk(1, 0, 0, 1, 0, 9'b0_0_1_0_0_0001);
      tbl[9]  = mk(1, 0, 0, 1, 0, 9'b0_0_0_0_0_0001);
      tbl[10] = mk(1, 0, 0, 1, 0, 9'b1_1_0_0_0_0001);
      tbl[11] = mk(1, 3, 1, 1, 0, 9'b1_0_0_0_0_0001);
      tbl[12] = mk(1, 0, 0, 1, 0, 9'b0_0_1_0_0_0011);
      tbl[13] = mk(1, 0, 0, 1, 0, 9'b0_0_0_0_0_0011);
      tbl[14] = mk(1, 0, 0, 1, 0, 9'b0_0_0_0_0_0011);
      tbl[15] = mk(1, 0, 0, 1, 0, 9'b0_0_0_0_0_0011);
      tbl[16] = mk(1, 0, 0, 1, 0, 9'b1_1_0_0_0_0011);
      tbl[17] = mk(1, 0, 0, 1, 0, 9'b1_0_0_0_0_0011);
      tbl[18] = mk(1, 0, 0, 1, 0, 9'b1_0_0_0_0_0011);
      tbl[19] = mk(1, 0, 0, 1, 0, 9'b1_0_0_0_0_0011);
      tbl[20] = mk(1, 0, 0, 1, 0, 9'b0_0_1_0_0_0011);

      for (int i = 0; i < 21; i++) begin
         reset_n = tbl[i].rn; div = tbl[i].d; div_load = tbl[i].ld;
         run = tbl[i].r; step = tbl[i].s;
         cyc();
         check($sformatf("tbl%0d", i), 32'(dut_vec()), 32'(tbl[i].exp));
      end
      div_load = 1'b0; div = '0;

      // Halt requested during the high phase: period completes, then parks low.
      n = 0;
      while (cpu_clk !== 1'b1 && n < 40) begin cyc(); n++; end
      check("wait_high", 32'(cpu_clk), 32'd1);
      run = 1'b0;
      n = 0;
      while (halted !== 1'b1 && n < 40) begin cyc(); n++; end
      check("halt_reached", 32'(halted), 32'd1);
      check("halt_clk_low", 32'(cpu_clk), 32'd0);
      viol = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (cpu_clk !== 1'b0 || cpu_rise !== 1'b0 || cpu_fall !== 1'b0 || halted !== 1'b1) viol++;
      end
      check("halt_quiet", 32'(viol), 32'd0);

      // Divisor load while halted is adopted on the next cycle.
      div = 4'd1; div_load = 1'b1; cyc(); div_load = 1'b0; cyc();
      check("halt_apply", 32'(div_active), 32'd1);

      // Single step: one rise 2 cycles later, one fall 2 after that, back to halt.
      step = 1'b1; cyc(); step = 1'b0;
      nr = 0; nf = 0; ra = 0; fa = 0; hf = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         cyc();
         if (cpu_rise === 1'b1) begin nr++; ra = i; end
         if (cpu_fall === 1'b1) begin nf++; fa = i; hf = halted; end
      end
      check("step_nrise", 32'(nr), 32'd1);
      check("step_rise_at", 32'(ra), 32'd2);
      check("step_nfall", 32'(nf), 32'd1);
      check("step_fall_at", 32'(fa), 32'd4);
      check("step_halt_on_fall", 32'(hf), 32'd1);

      // div=0: toggle every clk, rise and fall alternating.
      div = 4'd0; div_load = 1'b1; cyc(); div_load = 1'b0; cyc();
      check("div0_apply", 32'(div_active), 32'd0);
      run = 1'b1; cyc();
      viol = 0; nr = 0; prev = cpu_clk;
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (cpu_clk === prev || (cpu_rise ^ cpu_fall) !== 1'b1 || cpu_rise !== cpu_clk) viol++;
         if (cpu_rise === 1'b1) nr++;
         prev = cpu_clk;
      end
      check("div0_toggle", 32'(viol), 32'd0);
      check("div0_nrise", 32'(nr), 32'd4);

      // Reset in the high phase of a step abandons it cleanly.
      div = 4'd1; div_load = 1'b1; run = 1'b0; cyc(); div_load = 1'b0;
      n = 0;
      while (halted !== 1'b1 && n < 40) begin cyc(); n++; end
      check("halt2_reached", 32'(halted), 32'd1);
      cyc();
      step = 1'b1; cyc(); step = 1'b0; cyc(); cyc();
      check("step_high", 32'(cpu_clk), 32'd1);
      reset_n = 1'b0; cyc(); reset_n = 1'b1;
      check("step_reset", 32'(dut_vec()), 32'(9'b0_0_0_1_0_0001));

      // Random stimulus against the model.
      run = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         reset_n  = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 39) == 0) run = ~run;
         step     = ($urandom_range(0, 7) == 0);
         div_load = ($urandom_range(0, 29) == 0);
         div      = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                : 4'($urandom_range(0, 2));
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_clk_gen.md
CPU_CLK_GEN -- requirements
Module: cpu_clk_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 25, width of divisor and half-period counter.
REQ-002 SHALL have parameter DIV_RESET, default 2**(DIV_W-1)-1, divisor loaded at reset.
REQ-003 SHALL have parameter RESET_CYCLES, default 16, number of CPU clock periods cpu_reset is held after reset.
REQ-004 SHALL have one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  system (dot) clock; all logic on posedge.
REQ-006 reset_n  in  1  synchronous active-low reset.
REQ-007 div  in  DIV_W  requested divisor; CPU period = 2*(div+1) clk cycles.
REQ-008 div_load  in  1  one-cycle request to adopt div.
REQ-009 run  in  1  1 = free-run, 0 = halt at end of current period.
REQ-010 step  in  1  one-cycle request for one CPU period while halted.
REQ-011 cpu_clk  out  1  registered divided clock, 50% duty.
REQ-012 cpu_rise  out  1  one-clk pulse, cycle cpu_clk goes 0->1.
REQ-013 cpu_fall  out  1  one-clk pulse, cycle cpu_clk goes 1->0.
REQ-014 cpu_reset  out  1  active-high CPU reset.
REQ-015 halted  out  1  1 in HALT state.
REQ-016 div_active  out  DIV_W  divisor currently in use.

Function
REQ-017 States SHALL be RUN, HALT, STEP; all outputs registered.
REQ-018 Half-period counter SHALL count 0..div_active; at terminal count cpu_clk SHALL toggle and counter SHALL return to 0, in RUN and STEP.
REQ-019 cpu_rise/cpu_fall SHALL be high exactly in the clk cycle where cpu_clk shows its new value; never both high.
REQ-020 RUN->HALT SHALL occur when a rising toggle is due, cpu_clk=0 and run=0; toggle suppressed, cpu_clk stays 0, counter held 0.
REQ-021 HALT->RUN SHALL occur the cycle after run=1 sampled; first cpu_rise div_active+1 cycles after leaving HALT.
REQ-022 HALT->STEP on step=1 (run=0); STEP SHALL produce exactly one rise and one fall with normal timing, then go HALT if run=0 else RUN, on the cpu_fall cycle.
REQ-023 step SHALL be ignored in RUN and STEP; run=1 and step=1 together in HALT SHALL take RUN.
REQ-024 div_load SHALL capture div into a pending register and set pending flag; a later load before application SHALL overwrite it.
REQ-025 Pending divisor SHALL be applied to div_active in the cpu_fall cycle, or on the next cycle if in HALT; pending flag clears on apply; load coinciding with apply SHALL remain pending with the new value.
REQ-026 div=0 SHALL be legal: cpu_clk toggles every clk cycle (period 2).
REQ-027 Counter comparison SHALL be against div_active only; no width growth, no wrap beyond DIV_W.

Reset
REQ-028 With reset_n=0 at posedge: cpu_clk=0, cpu_rise=0, cpu_fall=0, counter=0, div_active=DIV_RESET, pending clear, state=RUN, halted=0, cpu_reset=1, reset-period counter=0.
REQ-029 After reset, cpu_reset SHALL deassert in the cycle of the RESET_CYCLES-th cpu_fall; only falls count (halt pauses the count).
REQ-030 Reset mid-period or mid-STEP SHALL abandon the period with no pulses emitted.

Structure
REQ-031 State encoding enum and DIV_RESET default SHALL live in shared package clkgen_pkg.
REQ-032 Reset-period counter SHALL be sub-module cpu_reset_seq (inputs clk, reset_n, cpu_fall; output cpu_reset).
REQ-033 No derived clocks other than the cpu_clk register; downstream logic SHALL prefer cpu_rise/cpu_fall enables.

Verification (DIV_W=4, DIV_RESET=1, RESET_CYCLES=2)
REQ-034 Release reset_n, run=1 -> cpu_clk period 4 clks, first cpu_rise at cycle 2, cpu_reset falls with 2nd cpu_fall (cycle 8).
REQ-035 div=3 with div_load mid-high-phase -> current period finishes at 4, next periods 8 clks; div_active=3 from the fall cycle.
REQ-036 run=0 while cpu_clk=1 -> period completes, halted=1, cpu_clk stays 0 for 20 cycles, no pulses.
REQ-037 Halted, step pulse -> exactly one cpu_rise 2 cycles later, one cpu_fall 2 after, halted returns 1.
REQ-038 div=0 loaded, run=1 -> cpu_clk toggles every clk, rise/fall alternate each cycle.
REQ-039 reset_n=0 during STEP high phase -> next cycle cpu_clk=0, cpu_reset=1, state RUN, div_active=1.
